mat_rd_streamer: RTL and testbench
==================================

// Module: mat_rd_streamer
// PURPOSE
//  Read-side master for the matrix data RAM (synchronous 1-cycle read: Q <= mem[rd_addr]).
//  - On start, drives rd_addr over len consecutive words from base_addr.
//  - Captures Q and presents the words as a valid/ready stream to the MFA compute datapath.
//  - A 2-entry skid FIFO absorbs the RAM read latency, so back-pressure never loses or duplicates a word.
// PARAMETERS
//  ADDR_LEN  6  RAM address is ADDR_LEN+1 bits wide (2**(ADDR_LEN+1) words)
//  DATA_LEN  8  RAM word / stream data width
// PORTS
//  CLK        in   1           clock; all state updates on posedge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           1-cycle request; sampled only in IDLE
//  base_addr  in   ADDR_LEN+1  first word address; sampled with start
//  len        in   ADDR_LEN+2  word count, 0..2**(ADDR_LEN+1); sampled with start
//  rd_addr    out  ADDR_LEN+1  RAM read address (combinational from the address counter)
//  Q          in   DATA_LEN    RAM read data, valid the cycle after the address was issued
//  out_data   out  DATA_LEN    stream data (FIFO head)
//  out_valid  out  1           stream valid
//  out_ready  in   1           stream ready; a beat transfers when out_valid & out_ready
//  out_last   out  1           high with the final beat of a transfer
//  busy       out  1           high from the cycle after an accepted start until done
//  done       out  1           1-cycle pulse, the cycle after the last beat transfers
// BEHAVIOUR
//  - Reset values: rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; FIFO empty; in-flight=0.
//  - FSM:
//    - IDLE -> RUN on start with len!=0: latch addr=base_addr, issue_left=len, beat_left=len.
//    - IDLE -> DONE on start with len==0: no RAM read, no beat.
//    - RUN -> DONE when beat_left reaches 0 at the final handshake.
//    - DONE -> IDLE after 1 cycle, asserting done during that cycle.
//  - Read issue in cycle t: fire = RUN & issue_left!=0 & (fifo_cnt + inflight - pop_t) < 2.
//    - On fire: addr += STEP, issue_left -= 1, inflight <= 1.
//    - Otherwise inflight <= 0.
//  - Data for a read fired in cycle t is on Q throughout cycle t+1 and is pushed into the FIFO at the end of t+1.
//  - Latency: start accepted in cycle 0 -> first fire in cycle 1 -> out_valid in cycle 3.
//  - Throughput: 1 beat/cycle while out_ready=1.
//  - FIFO can never overflow. The credit rule is the invariant; the bench asserts it.
//  - Address wraps modulo 2**(ADDR_LEN+1), e.g. base=126, len=4 reads 126,127,0,1.
//  - out_last = out_valid & (beat_left==1).
//  - out_data and out_valid stay stable while out_valid & !out_ready.
//  - Simultaneous push and pop on a full FIFO is legal, and so is push on an empty FIFO.
//  - start while busy (RUN/DONE) is ignored; the in-progress transfer is unaffected.
//  - len == 2**(ADDR_LEN+1) reads the whole RAM exactly once.
//  - Reset asserted mid-transfer: immediate return to reset values.
//    - The in-flight read is discarded.
//    - No done pulse.
//    - No further beats after release.
// CONFIGURATION
//  STRIDE_EN defined:
//   - Adds input stride [ADDR_LEN:0], sampled with start.
//   - STEP = stride, so a column walk of an NxN matrix uses stride = N.
//   - Wrap is still modulo 2**(ADDR_LEN+1).
//   - stride=0 repeats base_addr len times.
//  STRIDE_EN undefined: no stride port; STEP = 1.
// STRUCTURE
//  Package mfa_pkg:
//   - FSM state enum {IDLE, RUN, DONE}.
//   - Default ADDR_LEN/DATA_LEN constants.
//   - FIFO depth constant RD_FIFO_DEPTH = 2.
//  Sub-module rd_skid_fifo:
//   - 2-entry FIFO with push/pop/count.
//   - Head is registered and drives out_data/out_valid directly.
//  Top holds the FSM, address/issue/beat counters, in-flight flag and credit logic.
// TESTING
//  - RAM model preloaded with mem[i]=i. start, base=5, len=4, ready=1:
//    - beats 5,6,7,8 in cycles 3..6, out_last on 8, done in cycle 7.
//  - len=3, out_ready toggled 1,0,0,1,0,1:
//    - exactly 3 beats in order, no duplicates, data stable while stalled.
//    - fifo_cnt never exceeds 2.
//  - base=126, len=4 -> beats 126,127,0,1; len=128, base=0 -> 128 beats 0..127, one done pulse.
//  - len=0 -> done pulse 1 cycle after start, out_valid never asserted.
//  - start again while busy is ignored.
//  - rst_n low mid-transfer (after 2 of 6 beats):
//    - all outputs at reset values asynchronously.
//    - no done pulse.
//    - a new start after release streams correctly.
//  - STRIDE_EN, base=1, stride=8, len=8, ready random:
//    - beats 1,9,17,...,57.

Source files
------------

// File: rtl/mfa_pkg.sv
// Shared definitions for the matrix-fabric read path.
// Contents: FSM state encoding, default geometry, skid FIFO depth and the
// width of its occupancy counter.
package mfa_pkg;

  localparam int ADDR_LEN_DEF  = 6;
  localparam int DATA_LEN_DEF  = 8;
  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO between the RAM read port and the output stream.
// The head entry is a register that drives the stream directly.
// Ports:
//   CLK, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (RAM Q of the previous cycle's read)
//   pop        : head consumed this cycle (valid & ready)
//   head       : registered head word
//   valid      : FIFO not empty
//   count      : occupancy 0..RD_FIFO_DEPTH
module rd_skid_fifo
  import mfa_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_LEN-1:0]      din,
  output logic [DATA_LEN-1:0]      head,
  output logic                     valid,
  output logic [RD_FIFO_CNT_W-1:0] count
);

  localparam logic [RD_FIFO_CNT_W-1:0] ONE  = RD_FIFO_CNT_W'(1);
  localparam logic [RD_FIFO_CNT_W-1:0] FULL = RD_FIFO_CNT_W'(RD_FIFO_DEPTH);

  logic [DATA_LEN-1:0] tail;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == '0) head <= din;
          else             tail <= din;
          count <= count + ONE;
        end
        2'b01: begin
          head  <= tail;
          count <= count - ONE;
        end
        2'b11: begin
          // Occupancy unchanged; on a full FIFO the tail shifts up.
          if (count == FULL) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count != '0);

endmodule

// File: rtl/mat_rd_streamer.sv
// Read-side master for the matrix data RAM (1-cycle synchronous read).
// Walks len words from base_addr, captures Q and streams the words out
// over valid/ready through a 2-entry skid FIFO.
// Build option: macro STRIDE_EN adds a stride input (address step per
// word); without it the step is 1.
// Ports:
//   CLK, rst_n        : clock, asynchronous active-low reset
//   start             : transfer request, honoured only in IDLE
//   base_addr, len    : first address and word count, sampled with start
//   stride            : address step (STRIDE_EN builds only)
//   rd_addr, Q        : RAM read address / read data (one cycle later)
//   out_data/valid/ready/last : output stream
//   busy, done        : transfer in progress / one-cycle completion pulse
module mat_rd_streamer
  import mfa_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_LEN:0]   base_addr,
  input  logic [ADDR_LEN+1:0] len,
`ifdef STRIDE_EN
  input  logic [ADDR_LEN:0]   stride,
`endif
  output logic [ADDR_LEN:0]   rd_addr,
  input  logic [DATA_LEN-1:0] Q,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int LW = ADDR_LEN + 2;
  localparam int OW = RD_FIFO_CNT_W + 1;

  state_t                   state, state_nxt;
  logic [ADDR_LEN:0]        addr;
  logic [ADDR_LEN:0]        step;
  logic [LW-1:0]            issue_left;
  logic [LW-1:0]            beat_left;
  logic                     inflight;
  logic [RD_FIFO_CNT_W-1:0] fifo_cnt;
  logic [OW-1:0]            occ;
  logic                     pop;
  logic                     fire;
  logic                     accept;

`ifdef STRIDE_EN
  logic [ADDR_LEN:0] stride_q;
  assign step = stride_q;
`else
  assign step = (ADDR_LEN+1)'(1);
`endif

  assign accept  = (state == IDLE) && start;
  assign pop     = out_valid && out_ready;
  assign rd_addr = addr;

  // Credit: a read may only be issued if the word it returns is guaranteed
  // a FIFO slot, counting the read already in flight and this cycle's pop.
  assign occ  = OW'(fifo_cnt) + OW'(inflight) - OW'(pop);
  assign fire = (state == RUN) && (issue_left != '0) && (occ < OW'(RD_FIFO_DEPTH));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? RUN : DONE;
      RUN:     if (pop && beat_left == LW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      inflight   <= 1'b0;
`ifdef STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      inflight <= fire;
      if (accept) begin
        addr       <= base_addr;
        issue_left <= len;
        beat_left  <= len;
`ifdef STRIDE_EN
        stride_q   <= stride;
`endif
      end else begin
        if (fire) begin
          addr       <= addr + step;
          issue_left <= issue_left - LW'(1);
        end
        if (pop) beat_left <= beat_left - LW'(1);
      end
    end
  end

  rd_skid_fifo #(.DATA_LEN(DATA_LEN)) u_fifo (
    .CLK   (CLK),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (Q),
    .head  (out_data),
    .valid (out_valid),
    .count (fifo_cnt)
  );

  assign out_last = out_valid && (beat_left == LW'(1));

endmodule

// File: tb/tb_mat_rd_streamer.sv
// Bench for mat_rd_streamer: RAM model, queue-based reference model of the
// expected beat stream, per-cycle compare process, directed and random runs.
module tb_mat_rd_streamer;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] base_v;
  logic [7:0] len_v;
`ifdef STRIDE_EN
  logic [6:0] stride_v;
`endif
  logic [6:0] rd_addr;
  logic [7:0] Q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] mem [128];

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_log[$];
  logic       m_busy      = 1'b0;
  logic       m_done_pend = 1'b0;
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_data   = '0;

  int         ready_mode = 0;
  logic [0:8] pat = 9'b111100101;

  always #5 CLK = ~CLK;

  mat_rd_streamer dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_v),
    .len       (len_v),
`ifdef STRIDE_EN
    .stride    (stride_v),
`endif
    .rd_addr   (rd_addr),
    .Q         (Q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge CLK) Q <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ready driver: 0 = always ready, 1 = random, 2 = fixed pattern then ready
  always @(posedge CLK) begin : ready_drv
    int prev_mode;
    int idx;
    #1;
    if (ready_mode != prev_mode) idx = 0;
    prev_mode = ready_mode;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 9) < 6);
      default: begin
        out_ready = (idx < 9) ? pat[idx] : 1'b1;
        idx++;
      end
    endcase
  end

  // Reference model + per-cycle compare. Sampled mid-cycle, describing the
  // cycle before the next rising edge.
  always @(negedge CLK) begin : compare
    logic busy_old;
    int   st;
    if (!rst_n) begin
      exp_q.delete();
      m_busy      = 1'b0;
      m_done_pend = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      busy_old = m_busy;
      chk("done", done, m_done_pend);
      chk("busy", busy, m_busy);
      chk("fifo_cnt_le_2", (dut.fifo_cnt <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (exp_q.size() == 0) chk("valid_without_pending", out_valid, 0);
      if (!out_valid) chk("last_without_valid", out_last, 0);
      if (out_valid && exp_q.size() != 0) begin
        chk("data", out_data, exp_q[0]);
        chk("last", out_last, (exp_q.size() == 1));
      end
      if (m_done_pend) begin
        m_busy      = 1'b0;
        m_done_pend = 1'b0;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        got_log.push_back(out_data);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_done_pend = 1'b1;
      end
      if (start && !busy_old) begin
`ifdef STRIDE_EN
        st = int'(stride_v);
`else
        st = 1;
`endif
        m_busy = 1'b1;
        if (len_v == 0) m_done_pend = 1'b1;
        for (int k = 0; k < int'(len_v); k++)
          exp_q.push_back(mem[(int'(base_v) + k * st) % 128]);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge CLK); #1;
    start  = 1'b1;
    base_v = b[6:0];
    len_v  = l[7:0];
    @(posedge CLK); #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      @(negedge CLK); #1;
      n++;
    end
    if (m_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic chk_log(input string name, input int n0, input int b, input int st, input int l);
    chk({name, "_count"}, got_log.size() - n0, l);
    for (int k = 0; k < l && n0 + k < got_log.size(); k++)
      chk(name, got_log[n0 + k], (b + k * st) % 128);
  endtask

  initial begin : main
    int n0;
    int b, l, r;
    logic [7:0] wrap_exp [4];
    wrap_exp[0] = 8'd126; wrap_exp[1] = 8'd127; wrap_exp[2] = 8'd0; wrap_exp[3] = 8'd1;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    rst_n = 1'b0; start = 1'b0; base_v = '0; len_v = '0;
`ifdef STRIDE_EN
    stride_v = 7'd1;
`endif
    #12;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge CLK); #3 rst_n = 1'b1;
    repeat (2) @(posedge CLK);

    // base=5 len=4, always ready: beats in cycles 3..6, done in cycle 7
    ready_mode = 0;
    n0 = got_log.size();
    do_start(5, 4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      chk("lat_valid", out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("lat_data", out_data, c + 2);
      chk("lat_last", out_last, (c == 6));
      chk("lat_done", done, (c == 7));
    end
    wait_idle(20);
    chk_log("b5_beats", n0, 5, 1, 4);

    // len=0: done one cycle after start, never valid
    do_start(3, 0);
    @(negedge CLK);
    chk("len0_done", done, 1);
    chk("len0_valid", out_valid, 0);
    @(negedge CLK);
    chk("len0_done_gone", done, 0);
    wait_idle(10);

    // ready pattern 1,0,0,1,0,1 while data is presented
    ready_mode = 2;
    n0 = got_log.size();
    do_start(60, 3);
    wait_idle(40);
    chk_log("stall_beats", n0, 60, 1, 3);
    ready_mode = 0;

    // address wrap
    n0 = got_log.size();
    do_start(126, 4);
    wait_idle(30);
    chk("wrap_count", got_log.size() - n0, 4);
    for (int k = 0; k < 4 && n0 + k < got_log.size(); k++)
      chk("wrap_data", got_log[n0 + k], wrap_exp[k]);

    // whole RAM
    n0 = got_log.size();
    do_start(0, 128);
    wait_idle(300);
    chk_log("full_ram", n0, 0, 1, 128);

    // start while busy is ignored
    n0 = got_log.size();
    do_start(40, 10);
    repeat (3) @(posedge CLK);
    do_start(0, 2);
    wait_idle(60);
    chk_log("busy_start", n0, 40, 1, 10);

    // reset after 2 of 6 beats
    n0 = got_log.size();
    do_start(10, 6);
    for (int n = 0; n < 40 && got_log.size() < n0 + 2; n++) begin
      @(negedge CLK); #1;
    end
    chk("pre_reset_beats", got_log.size() - n0, 2);
    @(posedge CLK); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(posedge CLK);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge CLK);
    chk("post_rst_beats", got_log.size() - n0, 2);
    n0 = got_log.size();
    do_start(20, 5);
    wait_idle(40);
    chk_log("post_rst_stream", n0, 20, 1, 5);

`ifdef STRIDE_EN
    ready_mode = 1;
    stride_v = 7'd8;
    n0 = got_log.size();
    do_start(1, 8);
    wait_idle(100);
    chk_log("stride8", n0, 1, 8, 8);
    stride_v = 7'd1;
`endif

    // random transfers with random back-pressure and stray starts
    ready_mode = 1;
    for (int t = 0; t < 30; t++) begin
      b = $urandom_range(0, 127);
      r = $urandom_range(0, 9);
      l = (r == 0) ? 0 : (r == 1) ? 128 : $urandom_range(1, 20);
`ifdef STRIDE_EN
      stride_v = 7'($urandom_range(0, 127));
`endif
      do_start(b, l);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        do_start($urandom_range(0, 127), $urandom_range(0, 20));
      end
      wait_idle(2000);
    end
    ready_mode = 0;
    repeat (5) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
